// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared types and constants for the SPI flash read responder.
//   state_e      - responder FSM states
//   CMD_*        - supported opcodes
//   ADDR_BITS    - flash address length on the wire
//   SYNC_*       - bit positions of the pins in the synchronizer array
//   id_byte()    - selects one of the three JEDEC ID bytes, MSB byte first
package spi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_READ,
    ST_ID,
    ST_IGNORE
  } state_e;

  localparam logic [7:0] CMD_READ     = 8'h03;
  localparam logic [7:0] CMD_JEDEC_ID = 8'h9F;
  localparam int         ADDR_BITS    = 24;

  // Pin lanes of the synchronizer array
  localparam int NUM_PINS = 3;
  localparam int SYNC_SDI = 0;
  localparam int SYNC_CS  = 1;
  localparam int SYNC_SCK = 2;

  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = id[23:16];
      2'd1:    id_byte = id[15:8];
      default: id_byte = id[7:0];
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_responder_sync.sv
// spi_sync_edge: 2-FF synchronizer for one asynchronous pin, with optional
// rise/fall pulse generation from a third register.
//   clk_i, rst_ni : system clock, async active-low reset
//   d_i           : asynchronous pin
//   q_o           : synchronized level
//   rise_o/fall_o : one-cycle pulses on synchronized edges (tied 0 if EDGE_EN=0)
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0,
  parameter bit   EDGE_EN = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= {2{RST_VAL}};
    else         sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

  generate
    if (EDGE_EN) begin : g_edge
      logic dly_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) dly_q <= RST_VAL;
        else         dly_q <= sync_q[1];
      end
      assign rise_o = sync_q[1] & ~dly_q;
      assign fall_o = ~sync_q[1] & dly_q;
    end else begin : g_no_edge
      assign rise_o = 1'b0;
      assign fall_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 target emulating the read side of a serial
// NOR flash (READ 0x03, JEDEC-ID 0x9F), backed by a 1-cycle-latency byte memory.
//   clk_i, rst_ni            : system clock, async active-low reset
//   sck_i, cs_i, sdi_i       : SPI pins from the initiator (async, oversampled)
//   sdo_o, sdo_oe_o          : MISO data and pad output enable
//   mem_req_o, mem_addr_o    : single-cycle read strobe and byte address
//   mem_rdata_i              : read data, valid the cycle after mem_req_o
//   busy_o                   : FSM not idle
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          MEM_ADDR_WIDTH = 14,
  parameter logic [23:0] JEDEC_ID       = 24'hEF4018
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      sck_i,
  input  logic                      cs_i,
  input  logic                      sdi_i,
  output logic                      sdo_o,
  output logic                      sdo_oe_o,
  output logic                      mem_req_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [7:0]                mem_rdata_i,
  output logic                      busy_o
);

  // cs idles high; sck and sdi idle low
  localparam logic [NUM_PINS-1:0] SYNC_RST = NUM_PINS'(1) << SYNC_CS;

  logic [NUM_PINS-1:0] pin_raw, pin_q, pin_rise, pin_fall;

  assign pin_raw[SYNC_SCK] = sck_i;
  assign pin_raw[SYNC_CS]  = cs_i;
  assign pin_raw[SYNC_SDI] = sdi_i;

  generate
    for (genvar i = 0; i < NUM_PINS; i++) begin : g_sync
      spi_sync_edge #(
        .RST_VAL (SYNC_RST[i]),
        .EDGE_EN (i == SYNC_SCK)
      ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (pin_raw[i]),
        .q_o    (pin_q[i]),
        .rise_o (pin_rise[i]),
        .fall_o (pin_fall[i])
      );
    end
  endgenerate

  logic sck_rise, sck_fall, cs_q, sdi_q;
  assign sck_rise = pin_rise[SYNC_SCK];
  assign sck_fall = pin_fall[SYNC_SCK];
  assign cs_q     = pin_q[SYNC_CS];
  assign sdi_q    = pin_q[SYNC_SDI];

  state_e                 state;
  logic [2:0]             bit_cnt;
  logic [1:0]             byte_cnt;   // address bytes received
  logic [1:0]             id_idx;     // next ID byte to load
  logic [ADDR_BITS-1:0]   addr_sh;    // also holds the opcode during CMD
  logic [ADDR_BITS-1:0]   addr_nxt;
  logic [7:0]             out_sh;     // bits not yet driven onto sdo
  logic [7:0]             pre_byte;   // prefetched next byte
  logic                   first_byte; // next memory return goes straight to out_sh
  // vld_pipe[0]: request issued this cycle, vld_pipe[1]: read data on mem_rdata_i
  logic [1:0]             vld_pipe;

  assign addr_nxt  = {addr_sh[ADDR_BITS-2:0], sdi_q};
  assign mem_req_o = vld_pipe[0];
  assign busy_o    = (state != ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      id_idx     <= '0;
      addr_sh    <= '0;
      out_sh     <= '0;
      pre_byte   <= '0;
      first_byte <= 1'b0;
      vld_pipe   <= '0;
      mem_addr_o <= '0;
      sdo_o      <= 1'b0;
      sdo_oe_o   <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], 1'b0};
      // cs high overrides everything, including an sck edge in the same cycle
      if (cs_q) begin
        state      <= ST_IDLE;
        bit_cnt    <= '0;
        byte_cnt   <= '0;
        id_idx     <= '0;
        first_byte <= 1'b0;
        vld_pipe   <= '0;
        sdo_o      <= 1'b0;
        sdo_oe_o   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state    <= ST_CMD;
            bit_cnt  <= '0;
            byte_cnt <= '0;
          end

          ST_CMD: if (sck_rise) begin
            addr_sh <= addr_nxt;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (addr_nxt[7:0] == CMD_READ) begin
                state <= ST_ADDR;
              end else if (addr_nxt[7:0] == CMD_JEDEC_ID) begin
                state    <= ST_ID;
                out_sh   <= id_byte(JEDEC_ID, 2'd0);
                id_idx   <= 2'd1;
                sdo_oe_o <= 1'b1;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end

          ST_ADDR: if (sck_rise) begin
            addr_sh <= addr_nxt;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd2) begin
                // upper flash address bits are dropped here
                mem_addr_o  <= addr_nxt[MEM_ADDR_WIDTH-1:0];
                vld_pipe[0] <= 1'b1;
                first_byte  <= 1'b1;
                sdo_oe_o    <= 1'b1;
                state       <= ST_READ;
              end
            end
          end

          ST_READ: begin
            if (vld_pipe[1]) begin
              if (first_byte) begin
                out_sh      <= mem_rdata_i;
                first_byte  <= 1'b0;
                vld_pipe[0] <= 1'b1;
                mem_addr_o  <= mem_addr_o + MEM_ADDR_WIDTH'(1);
              end else begin
                pre_byte <= mem_rdata_i;
              end
            end
            if (sck_fall) begin
              sdo_o   <= out_sh[7];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                // last bit of this byte is out; swap in the prefetch, fetch the next
                out_sh      <= pre_byte;
                vld_pipe[0] <= 1'b1;
                mem_addr_o  <= mem_addr_o + MEM_ADDR_WIDTH'(1);
              end else begin
                out_sh <= {out_sh[6:0], 1'b0};
              end
            end
          end

          ST_ID: if (sck_fall) begin
            sdo_o   <= out_sh[7];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              out_sh <= id_byte(JEDEC_ID, id_idx);
              id_idx <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
            end else begin
              out_sh <= {out_sh[6:0], 1'b0};
            end
          end

          ST_IGNORE: ;

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Edge pulses of cs/sdi are constant 0; the address MSB only shifts out
  logic unused_sigs;
  assign unused_sigs = ^{pin_rise[SYNC_CS], pin_rise[SYNC_SDI],
                         pin_fall[SYNC_CS], pin_fall[SYNC_SDI], addr_sh[ADDR_BITS-1]};

endmodule

// File: tb/tb_spi_flash_responder.sv
module tb_spi_flash_responder;
  localparam int AW   = 14;
  localparam int MSZ  = 1 << AW;
  localparam int HALF = 4;   // sck half period in clk cycles

  logic          clk = 1'b0, rst_n = 1'b0, sck = 1'b0, cs = 1'b1, sdi = 1'b0;
  logic          sdo, sdo_oe, mem_req, busy;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata = 8'h00;

  spi_flash_responder #(.MEM_ADDR_WIDTH(AW), .JEDEC_ID(24'hEF4018)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sck_i(sck), .cs_i(cs), .sdi_i(sdi),
    .sdo_o(sdo), .sdo_oe_o(sdo_oe), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
    .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // memory model: 1-cycle latency, garbage when not requested
  logic [7:0] mem [MSZ];
  always @(posedge clk) mem_rdata <= mem_req ? mem[mem_addr] : 8'($urandom);

  int total = 0, bad = 0;
  int oe_viol = 0, b2b_viol = 0, ign_viol = 0;
  bit watch_ign = 1'b0;
  logic req_prev = 1'b0;
  logic [AW-1:0] req_q[$];

  always @(negedge clk) begin
    if (!sdo_oe && sdo)                  oe_viol  <= oe_viol + 1;
    if (mem_req && req_prev)             b2b_viol <= b2b_viol + 1;
    if (watch_ign && (sdo_oe || mem_req)) ign_viol <= ign_viol + 1;
    if (mem_req) req_q.push_back(mem_addr);
    req_prev <= mem_req;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic r);
    sdi = b;
    repeat (HALF) @(negedge clk);
    sck = 1'b1;
    r = sdo;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
  endtask

  task automatic cs_begin();
    @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]      cmd;
    logic [23:0]     addr;
    int              n;
    logic [0:7][7:0] exp;
  } vec_t;

  vec_t vecs[10];

  // reference: byte i of a READ at a is mem[(a + i) mod 2^AW]
  function automatic vec_t mk_read(input logic [23:0] a, input int n);
    vec_t v;
    v.cmd = 8'h03; v.addr = a; v.n = n; v.exp = '0;
    for (int i = 0; i < n; i++) v.exp[i] = mem[(int'(a) + i) % MSZ];
    return v;
  endfunction

  task automatic run_vec(input vec_t vv, input string tag);
    logic [7:0] rx, junk;
    int nreq;
    bit seq_ok;
    req_q.delete();
    cs_begin();
    spi_byte(vv.cmd, junk);
    if (vv.cmd == 8'h03) begin
      spi_byte(vv.addr[23:16], junk);
      spi_byte(vv.addr[15:8], junk);
      spi_byte(vv.addr[7:0], junk);
    end
    for (int i = 0; i < vv.n; i++) begin
      spi_byte(8'($urandom), rx);
      chk($sformatf("%s byte%0d", tag, i), 32'(rx), 32'(vv.exp[i]));
    end
    cs_end();
    chk({tag, " busy_after_cs"}, 32'(busy), 32'd0);
    chk({tag, " oe_after_cs"}, 32'(sdo_oe), 32'd0);
    nreq = req_q.size();
    if (vv.cmd == 8'h03) begin
      // initial fetch + prefetch + one refill per completed byte
      chk({tag, " req_count"}, 32'(nreq), 32'(vv.n + 2));
      seq_ok = (nreq > 0);
      for (int k = 0; k < nreq; k++)
        if (int'(req_q[k]) != (int'(vv.addr) + k) % MSZ) seq_ok = 1'b0;
      chk({tag, " req_addr_seq"}, 32'(seq_ok), 32'd1);
    end else begin
      chk({tag, " req_count"}, 32'(nreq), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] rx, junk;
    logic r;
    vec_t hv;

    for (int i = 0; i < MSZ; i++) mem[i] = 8'($urandom);
    mem[16'h10] = 8'hA5; mem[16'h11] = 8'h3C; mem[16'h12] = 8'hFF; mem[16'h13] = 8'h00;
    mem[16'h3FFE] = 8'h11; mem[16'h3FFF] = 8'h22; mem[0] = 8'h33; mem[1] = 8'h44;

    vecs[0] = '{cmd: 8'h03, addr: 24'h000010, n: 4, exp: {8'hA5, 8'h3C, 8'hFF, 8'h00, 32'h0}};
    vecs[1] = '{cmd: 8'h9F, addr: 24'h0,      n: 7, exp: {8'hEF, 8'h40, 8'h18, 8'hEF, 8'h40, 8'h18, 8'hEF, 8'h00}};
    vecs[2] = '{cmd: 8'h03, addr: 24'h003FFE, n: 4, exp: {8'h11, 8'h22, 8'h33, 8'h44, 32'h0}};
    vecs[3] = '{cmd: 8'h03, addr: 24'hFF3FFE, n: 4, exp: {8'h11, 8'h22, 8'h33, 8'h44, 32'h0}};
    for (int v = 4; v < 10; v++) vecs[v] = mk_read(24'($urandom), int'($urandom_range(1, 7)));

    // reset state
    repeat (3) @(negedge clk);
    chk("rst sdo", 32'(sdo), 32'd0);
    chk("rst sdo_oe", 32'(sdo_oe), 32'd0);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle busy", 32'(busy), 32'd0);

    for (int v = 0; v < 10; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // unknown opcode: stays silent until cs rises
    cs_begin();
    spi_byte(8'hAB, junk);
    watch_ign = 1'b1;
    spi_byte(8'($urandom), junk);
    spi_byte(8'($urandom), junk);
    chk("ign busy", 32'(busy), 32'd1);
    watch_ign = 1'b0;
    cs_end();
    chk("ign no_oe_no_req", 32'(ign_viol), 32'd0);
    run_vec(mk_read(24'h0, 1), "after_ign");

    // cs raised after 5 bits of the 2nd data byte
    cs_begin();
    spi_byte(8'h03, junk);
    spi_byte(8'h00, junk); spi_byte(8'h01, junk); spi_byte(8'h00, junk);
    spi_byte(8'h00, rx);
    chk("abort byte0", 32'(rx), 32'(mem[16'h100]));
    rx = '0;
    for (int b = 7; b >= 3; b--) begin spi_bit(1'b0, r); rx[b] = r; end
    chk("abort partial", 32'(rx[7:3]), 32'(mem[16'h101] >> 3));
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort oe", 32'(sdo_oe), 32'd0);
    chk("abort sdo", 32'(sdo), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
    run_vec(mk_read(24'h000020, 3), "after_abort");

    // reset mid-ADDR
    cs_begin();
    spi_byte(8'h03, junk);
    spi_byte(8'h12, junk);
    for (int b = 0; b < 3; b++) spi_bit(1'b1, r);
    chk("mid_addr busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst sdo", 32'(sdo), 32'd0);
    chk("arst sdo_oe", 32'(sdo_oe), 32'd0);
    chk("arst mem_req", 32'(mem_req), 32'd0);
    chk("arst mem_addr", 32'(mem_addr), 32'd0);
    chk("arst busy", 32'(busy), 32'd0);
    cs = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    hv = mk_read(24'($urandom), 3);
    run_vec(hv, "after_rst");

    chk("sdo zero when oe low", 32'(oe_viol), 32'd0);
    chk("no back-to-back req", 32'(b2b_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
